mem_port_arbiter: RTL and testbench
===================================

Name:
mem_port_arbiter

Overview:
- Shares the single data-memory port between instruction fetch (IF) and the load/store unit (LS).
- Decodes each request against the Parameters memory map (instruction, static and dynamic regions), faults illegal or misaligned accesses without touching memory, and returns every response on one shared, tagged response bus. At most one transaction is outstanding.

Parameters:
- MaxLsuStreak, 4: consecutive LS grants allowed while IF is waiting (ARB_FAIR_EN only); legal range 1..15.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
if_req_valid  in  1  fetch request valid
if_req_ready  out  1  fetch request accepted this cycle
if_req_addr  in  32  fetch byte address
ls_req_valid  in  1  load/store request valid
ls_req_ready  out  1  load/store request accepted this cycle
ls_req_addr  in  32  load/store byte address
ls_req_we  in  1  1 = store, 0 = load
ls_req_wdata  in  32  store data
rsp_valid  out  1  one-cycle response pulse
rsp_id  out  1  0 = IF, 1 = LS
rsp_data  out  32  read data; 0 for stores and faults
rsp_fault  out  1  access fault
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  byte address, absolute
mem_req_we  out  1  write enable
mem_req_wdata  out  32  write data
mem_req_region  out  2  0 INST, 1 STATIC, 2 DYNAMIC
mem_rsp_valid  in  1  memory response or write acknowledge, at least 1 cycle after acceptance
mem_rsp_rdata  in  32  memory read data

Behaviour:
- **Reset:** all outputs are 0. The FSM goes to IDLE and the streak counter to 0. Reset in any state drops the pending transaction and no response is issued.
- **Region decode** (byte ranges, half-open):
  - INST = [InstStartFrom, InstStartFrom+InstSpace)
  - STATIC = [MemStaticStartFrom, +MemStaticSpace)
  - DYNAMIC = [MemDynamicStartFrom, +MemDynamicSpace)
  - Compute all bounds in 33 bits so the end address cannot wrap.
- **Fault rules:**
  - IF is legal only in INST; LS is legal only in STATIC or DYNAMIC.
  - addr[1:0] != 0 faults for both requesters.
- **State IDLE:**
  - Ready is asserted combinationally to the winner only: LS if ls_req_valid, else IF. Both valid means LS wins.
  - On handshake, the address, we, wdata, id and region are registered.
  - Next state is FAULT if the decode faults, else ISSUE.
- **State ISSUE:** mem_req_valid = 1 with the registered fields held stable. On mem_req_ready go to WAIT.
- **State WAIT:**
  - On mem_rsp_valid, the next cycle drives rsp_valid = 1, rsp_id, rsp_fault = 0, and rsp_data = rdata for loads and fetches or 0 for stores.
  - The FSM returns to IDLE in that same cycle, so a new request can be accepted while the response is driven.
- **State FAULT:** the next cycle drives rsp_valid = 1, rsp_fault = 1, rsp_data = 0, and the FSM returns to IDLE. mem_req_valid is never asserted for a faulted request.
- **Latency:**
  - Minimum accept-to-response is 3 cycles for a memory access and 1 cycle for a fault.
  - Both ready outputs are 0 outside IDLE.
- **Unexpected responses:** mem_rsp_valid outside WAIT is ignored and flagged by a simulation-only assertion.

Optional Feature:
ARB_FAIR_EN:
- **Defined:**
  - A 4-bit streak counter increments on each LS grant made while if_req_valid is high.
  - When streak == MaxLsuStreak and IF is valid, IF wins even if LS is valid.
  - The counter clears on any IF grant and on any cycle with if_req_valid low.
- **Undefined:** strict LS priority with no counter logic.

Decomposition:
- **Package additions** (reusing InstStartFrom, InstSpace and the Mem* constants):
  - typedef enum logic [1:0] region_t {INST, STATIC, DYNAMIC, NONE}
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT, FAULT}
  - REQ_IF/REQ_LS id constants
- **Sub-module:** addr_region_decode (combinational, inputs addr and id; outputs region_t and fault). It is reused later by the LSU.

Test Plan:
- IF 0x0000_0010, memory returns 0x0000_0013 after 2 cycles → mem_req_region 0; rsp_valid with id 0, data 0x13, fault 0.
- LS store 0x1000_8004 / 0xDEADBEEF → mem_req_we 1, region 2, wdata 0xDEADBEEF; ack gives rsp id 1, data 0, fault 0.
- LS load 0x1000_0020 (one past STATIC end), then LS load 0x1000_0002 (misaligned) → each gives rsp_fault 1 one cycle after accept, with mem_req_valid never high.
- IF and LS both valid continuously, memory always ready:
  - Default: every grant goes to LS.
  - With ARB_FAIR_EN and MaxLsuStreak = 2: grant sequence LS, LS, IF, LS, LS, IF.
- rst pulsed while in WAIT, then mem_rsp_valid arrives → no rsp_valid, FSM in IDLE, ready restored on the next valid request.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, memory map and id constants for the data-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam logic [31:0] InstStartFrom       = 32'h0000_0000;
  localparam logic [31:0] InstSpace           = 32'h0001_0000;
  localparam logic [31:0] MemStaticStartFrom  = 32'h1000_0000;
  localparam logic [31:0] MemStaticSpace      = 32'h0000_0020;
  localparam logic [31:0] MemDynamicStartFrom = 32'h1000_8000;
  localparam logic [31:0] MemDynamicSpace     = 32'h0000_8000;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  typedef enum logic [1:0] {
    INST    = 2'd0,
    STATIC  = 2'd1,
    DYNAMIC = 2'd2,
    NONE    = 2'd3
  } region_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FAULT = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        id;
    region_t     region;
  } req_t;

  // Half-open window test done in 33 bits so base+size never wraps.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_addr_region_decode.sv
// Purpose: classify a byte address into a memory region and flag illegal access.
// Latency: combinational. Backpressure: none, pure decode.
module addr_region_decode
  import mem_port_arbiter_pkg::*;
(
  input  logic [31:0] addr,
  input  logic        id,
  output region_t     region,
  output logic        fault
);

  always_comb begin
    region = NONE;
    if (in_window(addr, InstStartFrom, InstSpace)) begin
      region = INST;
    end else if (in_window(addr, MemStaticStartFrom, MemStaticSpace)) begin
      region = STATIC;
    end else if (in_window(addr, MemDynamicStartFrom, MemDynamicSpace)) begin
      region = DYNAMIC;
    end

    fault = (addr[1:0] != 2'b00);
    if (id == REQ_IF) begin
      if (region != INST) fault = 1'b1;
    end else begin
      if ((region != STATIC) && (region != DYNAMIC)) fault = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: share one data-memory port between fetch and load/store, one transaction in flight.
// Latency: 3+ cycles accept-to-response for memory, 1 for faults; ready only in IDLE (ARB_FAIR_EN adds IF anti-starvation).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MaxLsuStreak = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [31:0] ls_req_addr,
  input  logic        ls_req_we,
  input  logic [31:0] ls_req_wdata,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_fault,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [31:0] mem_req_wdata,
  output logic [1:0]  mem_req_region,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata
);

  if ((MaxLsuStreak < 1) || (MaxLsuStreak > 15)) begin : g_bad_streak
    $error("MaxLsuStreak must be within 1..15");
  end

  arb_state_t  state_q, state_d;
  req_t        req_q;
  logic        force_if, grant_ls, grant_if, accept;
  logic        sel_id;
  logic [31:0] sel_addr;
  region_t     dec_region;
  logic        dec_fault;

  assign grant_ls = ls_req_valid && !force_if;
  assign grant_if = if_req_valid && !grant_ls;
  assign sel_id   = grant_ls ? REQ_LS : REQ_IF;
  assign sel_addr = grant_ls ? ls_req_addr : if_req_addr;

  addr_region_decode u_decode (
    .addr   (sel_addr),
    .id     (sel_id),
    .region (dec_region),
    .fault  (dec_fault)
  );

  always_comb begin
    state_d       = state_q;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          ls_req_ready = grant_ls;
          if_req_ready = grant_if;
        end
        if (grant_ls || grant_if) state_d = dec_fault ? FAULT : ISSUE;
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) state_d = IDLE;
      end
      FAULT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = if_req_ready || ls_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.addr   <= sel_addr;
        req_q.we     <= grant_ls && ls_req_we;
        req_q.wdata  <= (grant_ls && ls_req_we) ? ls_req_wdata : '0;
        req_q.id     <= sel_id;
        req_q.region <= dec_region;
      end
    end
  end

  // Faults respond from the accept itself, so the response shows up while in FAULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
      if (accept && dec_fault) begin
        rsp_valid <= 1'b1;
        rsp_id    <= sel_id;
        rsp_fault <= 1'b1;
      end else if ((state_q == WAIT) && mem_rsp_valid) begin
        rsp_valid <= 1'b1;
        rsp_id    <= req_q.id;
        rsp_data  <= req_q.we ? '0 : mem_rsp_rdata;
      end
    end
  end

  assign mem_req_addr   = req_q.addr;
  assign mem_req_we     = req_q.we;
  assign mem_req_wdata  = req_q.wdata;
  assign mem_req_region = req_q.region;

`ifdef ARB_FAIR_EN
  logic [3:0] streak_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else if (!if_req_valid || if_req_ready) begin
      streak_q <= '0;
    end else if (ls_req_ready) begin
      streak_q <= streak_q + 4'd1;
    end
  end

  assign force_if = if_req_valid && (streak_q == 4'(MaxLsuStreak));
`else
  assign force_if = 1'b0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_rsp_valid && (state_q != WAIT)))
        else $warning("mem_rsp_valid outside WAIT ignored");
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected responses and memory requests are
// queued at accept time and compared when the DUT produces them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_req_addr;
  logic        ls_req_valid, ls_req_ready, ls_req_we;
  logic [31:0] ls_req_addr, ls_req_wdata;
  logic        rsp_valid, rsp_id, rsp_fault;
  logic [31:0] rsp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [1:0]  mem_req_region;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        fault;
    int          cyc;
  } rsp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  region;
  } mem_exp_t;

  rsp_exp_t    rsp_q[$];
  mem_exp_t    mem_q[$];
  logic        grant_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          mem_lat  = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;
  logic        mem_auto = 1'b1;
  logic        mem_seen = 1'b0;

  mem_port_arbiter #(.MaxLsuStreak(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_req_addr    (if_req_addr),
    .ls_req_valid   (ls_req_valid),
    .ls_req_ready   (ls_req_ready),
    .ls_req_addr    (ls_req_addr),
    .ls_req_we      (ls_req_we),
    .ls_req_wdata   (ls_req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_data       (rsp_data),
    .rsp_fault      (rsp_fault),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_we     (mem_req_we),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_region (mem_req_region),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_rdata  (mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] tb_region(input logic [31:0] a);
    if (a < 32'h0001_0000) return 2'd0;
    if (a >= 32'h1000_0000 && a < 32'h1000_0020) return 2'd1;
    if (a >= 32'h1000_8000 && a < 32'h1001_0000) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic tb_fault(input logic id, input logic [31:0] a);
    logic [1:0] r;
    r = tb_region(a);
    if (a[1:0] != 2'b00) return 1'b1;
    if (id == 1'b0) return r != 2'd0;
    return !(r == 2'd1 || r == 2'd2);
  endfunction

  task automatic push_req(input logic id, input logic [31:0] a, input logic we, input logic [31:0] wd);
    logic f;
    f = tb_fault(id, a);
    rsp_q.push_back('{id, (f || we) ? 32'h0 : a + 32'd3, f, cyc});
    if (!f) mem_q.push_back('{a, we, we ? wd : 32'h0, tb_region(a)});
    grant_log.push_back(id);
  endtask

  // Accept, memory-request and response monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (ls_req_valid && ls_req_ready) push_req(1'b1, ls_req_addr, ls_req_we, ls_req_wdata);
      if (if_req_valid && if_req_ready) push_req(1'b0, if_req_addr, 1'b0, 32'h0);
      if (mem_req_valid && mem_req_ready) begin
        mem_exp_t m;
        mem_seen = 1'b1;
        if (mem_q.size() == 0) begin
          check("mem_req_unexpected", mem_q.size(), 1);
        end else begin
          m = mem_q.pop_front();
          check("mem_addr", mem_req_addr, m.addr);
          check("mem_we", 32'(mem_req_we), 32'(m.we));
          check("mem_wdata", mem_req_wdata, m.wdata);
          check("mem_region", 32'(mem_req_region), 32'(m.region));
        end
        if (mem_auto) begin
          pend_cnt  = mem_lat;
          pend_data = mem_req_addr + 32'd3;
        end
      end
      if (rsp_valid) begin
        rsp_exp_t e;
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", rsp_q.size(), 1);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_data", rsp_data, e.data);
          check("rsp_fault", 32'(rsp_fault), 32'(e.fault));
          check("rsp_latency", cyc - e.cyc, e.fault ? 1 : 2 + mem_lat);
        end
      end
    end
  end

  // Memory model: one-cycle response pulse mem_lat cycles after the handshake
  always @(posedge clk) begin
    #1;
    mem_rsp_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = pend_data;
      end
    end
  end

  task automatic wait_accept(input logic is_ls, output int waited);
    logic got;
    got    = 1'b0;
    waited = 0;
    while (waited < 100 && !got) begin
      @(negedge clk);
      got = is_ls ? ls_req_ready : if_req_ready;
      waited++;
    end
    check(is_ls ? "ls_accept" : "if_accept", 32'(got), 32'd1);
    @(posedge clk);
    #2;
    if (is_ls) ls_req_valid = 1'b0;
    else       if_req_valid = 1'b0;
  endtask

  task automatic send_if(input logic [31:0] a, output int waited);
    @(posedge clk);
    #2;
    if_req_valid = 1'b1;
    if_req_addr  = a;
    wait_accept(1'b0, waited);
  endtask

  task automatic send_ls(input logic [31:0] a, input logic we, input logic [31:0] wd);
    int w;
    @(posedge clk);
    #2;
    ls_req_valid = 1'b1;
    ls_req_addr  = a;
    ls_req_we    = we;
    ls_req_wdata = wd;
    wait_accept(1'b1, w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", rsp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, n, seen;
    logic exp_g[6];
    rst           = 1'b1;
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h0;
    ls_req_valid  = 1'b1;
    ls_req_addr   = 32'h1000_0000;
    ls_req_we     = 1'b0;
    ls_req_wdata  = 32'h0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_if_ready", 32'(if_req_ready), 32'd0);
    check("rst_ls_ready", 32'(ls_req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_addr", mem_req_addr, 32'h0);
    check("rst_mem_region", 32'(mem_req_region), 32'd0);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Fetch with a two-cycle memory
    mem_lat = 2;
    send_if(32'h0000_0010, w);
    drain();

    // Store to the dynamic region
    mem_lat = 1;
    send_ls(32'h1000_8004, 1'b1, 32'hDEAD_BEEF);
    drain();

    // Faults must never reach memory
    mem_seen = 1'b0;
    send_ls(32'h1000_0020, 1'b0, 32'h0);
    drain();
    send_ls(32'h1000_0002, 1'b0, 32'h0);
    drain();
    send_if(32'h1000_0000, w);
    drain();
    send_ls(32'h0000_0100, 1'b1, 32'h1234_5678);
    drain();
    send_if(32'h0001_0000, w);
    drain();
    send_ls(32'h1001_0000, 1'b0, 32'h0);
    drain();
    check("fault_no_mem", 32'(mem_seen), 32'd0);

    // Region edges that are still legal
    send_ls(32'h1000_001C, 1'b0, 32'h0);
    drain();
    send_if(32'h0000_FFFC, w);
    drain();
    send_ls(32'h1000_FFFC, 1'b0, 32'h0);
    drain();

    // Both requesters valid continuously
    grant_log.delete();
    @(posedge clk);
    #2;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0020;
    ls_req_valid = 1'b1;
    ls_req_addr  = 32'h1000_0008;
    ls_req_we    = 1'b0;
    n = 0;
    while (grant_log.size() < 6 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    drain();
    check("grant_count", grant_log.size(), 6);
`ifdef ARB_FAIR_EN
    begin
      int s;
      s = 0;
      for (int i = 0; i < 6; i++) begin
        if (s == 2) begin
          exp_g[i] = 1'b0;
          s = 0;
        end else begin
          exp_g[i] = 1'b1;
          s++;
        end
      end
    end
`else
    for (int i = 0; i < 6; i++) exp_g[i] = 1'b1;
`endif
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      check($sformatf("grant_%0d", i), 32'(grant_log[i]), 32'(exp_g[i]));
    end

    // Reset while waiting on memory, then a stray response
    mem_auto = 1'b0;
    mem_seen = 1'b0;
    send_ls(32'h1000_0004, 1'b0, 32'h0);
    n = 0;
    while (!mem_seen && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_reached", 32'(mem_seen), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    rsp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_mem_valid", 32'(mem_req_valid), 32'd0);
    @(posedge clk);
    #2;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0000_0055;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rst_no_rsp", seen, 0);
    mem_auto = 1'b1;
    send_if(32'h0000_0040, w);
    check("rst_ready_restored", w, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
